// File: rtl/sparse_row_sequencer.sv
// ============================================================================
// Module      : sparse_row_sequencer
// Description : Packet FIFO + issue sequencer feeding one sparse PE; emits
//               per-row accumulator deltas on a valid/ready result stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparse_row_sequencer #(
    parameter int GROUPS_PER_ROW = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int PSUM_W         = 20,
    parameter int PKT_W          = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PKT_W-1:0]  s_pkt,
    output logic              pe_en,
    output logic [PKT_W-1:0]  pe_w,
    input  logic [PSUM_W-1:0] pe_psum,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PSUM_W-1:0] m_data,
    output logic              busy
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = (GROUPS_PER_ROW > 1) ? $clog2(GROUPS_PER_ROW) : 1;

    localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_GRP_LAST = c_CNT_W'(GROUPS_PER_ROW - 1);

    localparam logic [1:0] c_ST_RUN     = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_OUT     = 2'd2;

    logic [PKT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_grp_cnt;
    logic [PSUM_W-1:0]  r_base;
    logic [PSUM_W-1:0]  r_m_data;
    logic               r_m_valid;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_issue;
    logic               w_row_last;

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    assign s_ready    = rst_n && !w_full;
    assign w_push     = s_valid && s_ready;
    assign w_row_last = (r_grp_cnt == c_GRP_LAST);
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;

    // Storage is not reset: occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN:     if (w_issue && w_row_last) w_state_nxt = c_ST_CAPTURE;
            c_ST_CAPTURE: w_state_nxt = c_ST_OUT;
            c_ST_OUT:     if (m_ready) w_state_nxt = c_ST_RUN;
            default:      w_state_nxt = c_ST_RUN;
        endcase
    end

    always_comb begin
        w_issue = (r_state == c_ST_RUN) && !w_empty;
        pe_en   = w_issue && rst_n;
        pe_w    = pe_en ? r_mem[r_rd_ptr] : '0;
        busy    = !w_empty || (r_state != c_ST_RUN);
    end

    // The PE never clears, so each row result is the psum delta since the last capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grp_cnt <= '0;
            r_base    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (w_issue) begin
                r_grp_cnt <= w_row_last ? '0 : r_grp_cnt + c_CNT_W'(1);
            end
            case (r_state)
                c_ST_CAPTURE: begin
                    r_m_data  <= pe_psum - r_base;
                    r_base    <= pe_psum;
                    r_m_valid <= 1'b1;
                end
                c_ST_OUT: begin
                    if (m_ready) r_m_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sparse_row_sequencer.sv
// ============================================================================
// Module      : tb_sparse_row_sequencer
// Description : Scoreboard bench with a behavioural PE and row-sum reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sparse_row_sequencer;

    localparam int G      = 4;
    localparam int DEPTH  = 4;
    localparam int PSUM_W = 20;
    localparam int PKT_W  = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [PKT_W-1:0]  s_pkt = '0;
    logic              pe_en;
    logic [PKT_W-1:0]  pe_w;
    logic [PSUM_W-1:0] pe_psum = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [PSUM_W-1:0] m_data;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    int act [4] = '{4, 3, 2, 1};

    sparse_row_sequencer #(
        .GROUPS_PER_ROW(G),
        .FIFO_DEPTH    (DEPTH),
        .PSUM_W        (PSUM_W),
        .PKT_W         (PKT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_pkt  (s_pkt),
        .pe_en  (pe_en),
        .pe_w   (pe_w),
        .pe_psum(pe_psum),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Packet layout: {idx1[1:0], idx0[1:0], val1[7:0], val0[7:0]}
    function automatic logic [PKT_W-1:0] mk(input int v0, input int v1, input int i0, input int i1);
        logic [7:0] b0, b1;
        logic [1:0] x0, x1;
        b0 = 8'(v0); b1 = 8'(v1); x0 = 2'(i0); x1 = 2'(i1);
        return {x1, x0, b1, b0};
    endfunction

    function automatic int dot(input logic [PKT_W-1:0] p);
        return int'($signed(p[7:0])) * act[p[17:16]] + int'($signed(p[15:8])) * act[p[19:18]];
    endfunction

    // Behavioural PE: accumulates one dot product per enabled cycle, cleared by reset.
    always @(posedge clk) begin
        if (!rst_n) pe_psum <= '0;
        else if (pe_en) pe_psum <= pe_psum + PSUM_W'(dot(pe_w));
    end

    function automatic void chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act_v, exp_v, $time);
        end
    endfunction

    // Reference model and scoreboard state
    logic [PKT_W-1:0]  iss_q [$];
    logic [PSUM_W-1:0] exp_q [$];
    int                row_acc = 0;
    int                row_n = 0;
    int                occ = 0;
    int                issued = 0;
    int                cycle = 0;
    int                last_issue = -10;
    int                rows_seen = 0;
    logic              prev_mv = 1'b0;
    logic              after_rst = 1'b0;
    logic [PSUM_W-1:0] held = '0;

    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            chk("rst_s_ready", 32'(s_ready), 32'd0);
            chk("rst_pe_en", 32'(pe_en), 32'd0);
            chk("rst_pe_w", 32'(pe_w), 32'd0);
            iss_q.delete();
            exp_q.delete();
            row_acc = 0; row_n = 0; occ = 0; issued = 0;
            last_issue = -10; prev_mv = 1'b0; after_rst = 1'b1;
        end else begin
            if (after_rst) begin
                chk("post_rst_m_valid", 32'(m_valid), 32'd0);
                chk("post_rst_m_data", 32'(m_data), 32'd0);
                after_rst = 1'b0;
            end
            chk("s_ready_vs_occ", 32'(s_ready), 32'(occ < DEPTH));
            if (s_valid && s_ready) begin
                iss_q.push_back(s_pkt);
                row_acc += dot(s_pkt);
                row_n++;
                occ++;
                if (row_n == G) begin
                    exp_q.push_back(PSUM_W'(row_acc));
                    row_acc = 0;
                    row_n = 0;
                end
            end
            if (pe_en) begin
                if (iss_q.size() == 0) begin
                    chk("issue_without_packet", 32'(pe_w), 32'hFFFF_FFFF);
                end else begin
                    chk("pe_w_order", 32'(pe_w), 32'(iss_q.pop_front()));
                end
                chk("no_issue_in_out", 32'(m_valid), 32'd0);
                occ--;
                issued++;
                if (issued % G == 0) last_issue = cycle;
            end else begin
                chk("pe_w_idle_zero", 32'(pe_w), 32'd0);
            end
            if (cycle == last_issue + 1) chk("no_issue_in_capture", 32'(pe_en), 32'd0);
            if (m_valid && !prev_mv) begin
                chk("latency", 32'(cycle - last_issue), 32'd2);
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                held = m_data;
                rows_seen++;
            end else if (m_valid) begin
                chk("m_data_stable", 32'(m_data), 32'(held));
            end
            prev_mv = m_valid;
        end
    end

    task automatic send(input logic [PKT_W-1:0] p);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_pkt   = p;
        forever begin
            @(negedge clk);
            if (s_ready && rst_n) break;
            n++;
            if (n > 300) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_pkt   = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy && !m_valid) break;
            n++;
            if (n > 500) begin
                chk("idle_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done;
        rst_n   = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed rows back to back
        for (int i = 0; i < G; i++) send(mk(1, 1, 0, 1));
        for (int i = 0; i < G; i++) send(mk(2, -1, 2, 3));
        wait_idle();

        // Result backpressure while input keeps streaming
        fork
            begin
                for (int i = 0; i < 3 * G; i++)
                    send(mk(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
            end
            begin
                m_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        wait_idle();

        // Abort a row after two issues, then a full row from a clean start
        send(mk(5, 7, 1, 2));
        send(mk(-3, 9, 0, 3));
        wait_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < G; i++) send(mk(-128, 127, 0, 3));
        wait_idle();

        // Randomised traffic with random result backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 15 * G; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(mk(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 m_ready = ($urandom_range(0, 3) != 0);
                end
                m_ready = 1'b1;
            end
        join
        wait_idle();

        chk("results_pending", 32'(exp_q.size()), 32'd0);
        chk("packets_pending", 32'(iss_q.size()), 32'd0);
        chk("rows_seen", 32'(rows_seen), 32'd21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
